// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32 data-memory port: access-size codes and the
// response record carried through the response FIFO.
package rv_mem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        store;
  } rsp_entry_t;

  // Misaligned halfword/word and the reserved size never reach the RAM.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_H && off[0]) ||
           (size == SIZE_W && off != 2'b00) ||
           (size == SIZE_RSV);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous FIFO of response entries with wrap-around pointers and an
// explicit occupancy count that the initiator uses for request credits.
module rsp_fifo
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rsp_entry_t    wdata,
  input  logic          pop,
  output rsp_entry_t    head,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  rsp_entry_t    mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
      end
      if (pop) begin
        rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/dmem_port_initiator.sv
// LSU-side initiator for one byte-enabled synchronous RAM port: request decode,
// one-cycle read stage, load formatting and credit-based response buffering.
module dmem_port_initiator
  import rv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_store,
  output logic                    ram_en,
  output logic [3:0]              ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0] fifo_count;
  rsp_entry_t    fifo_head;
  rsp_entry_t    push_entry;
  logic          req_err;
  logic          accept;
  logic          fire;
  logic [1:0]    off;
  logic [3:0]    lane_we;

  logic          p_valid;
  logic          p_we;
  logic [1:0]    p_size;
  logic          p_unsigned;
  logic [1:0]    p_off;
  logic          p_err;

  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [31:0]   load_fmt;

  // Credits count both buffered responses and the one in stage P, so P can
  // always push without ever stalling the RAM read.
  assign req_ready = (int'(fifo_count) + int'(p_valid)) < RSP_DEPTH;

  assign off      = req_addr[1:0];
  assign req_err  = size_err(req_size, off);
  assign accept   = req_valid & req_ready;
  assign fire     = accept & ~req_err;
  assign ram_en   = fire;
  assign ram_addr = req_addr[ADDR_WIDTH+1:2];

  always_comb begin
    lane_we = 4'b0000;
    ram_din = req_wdata;
    unique case (req_size)
      SIZE_B: begin
        lane_we = 4'b0001 << off;
        ram_din = {4{req_wdata[7:0]}};
      end
      SIZE_H: begin
        lane_we = 4'b0011 << off;
        ram_din = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_we = 4'b1111;
        ram_din = req_wdata;
      end
    endcase
    ram_we = (fire & req_we) ? lane_we : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid    <= 1'b0;
      p_we       <= 1'b0;
      p_size     <= SIZE_B;
      p_unsigned <= 1'b0;
      p_off      <= 2'b00;
      p_err      <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_we       <= req_we;
        p_size     <= req_size;
        p_unsigned <= req_unsigned;
        p_off      <= off;
        p_err      <= req_err;
      end
    end
  end

  // ram_dout is only meaningful while P holds a non-error load.
  always_comb begin
    load_byte = ram_dout[{p_off, 3'b000} +: 8];
    load_half = ram_dout[{p_off[1], 4'b0000} +: 16];
    unique case (p_size)
      SIZE_B:  load_fmt = p_unsigned ? {24'h000000, load_byte}
                                     : {{24{load_byte[7]}}, load_byte};
      SIZE_H:  load_fmt = p_unsigned ? {16'h0000, load_half}
                                     : {{16{load_half[15]}}, load_half};
      default: load_fmt = ram_dout;
    endcase
    push_entry.rdata = (p_err | p_we) ? 32'h0 : load_fmt;
    push_entry.err   = p_err;
    push_entry.store = p_we;
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (p_valid),
    .wdata (push_entry),
    .pop   (rsp_valid & rsp_ready),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_rdata = rsp_valid ? fifo_head.rdata : '0;
  assign rsp_err   = rsp_valid & fifo_head.err;
  assign rsp_store = rsp_valid & fifo_head.store;

endmodule

// File: tb/tb_dmem_port_initiator.sv
// Randomized bench for dmem_port_initiator: a byte-addressed reference memory
// and an ordered response queue predict every RAM strobe and response.
module tb_dmem_port_initiator;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_store;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  always #5 clk = ~clk;

  dmem_port_initiator #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .RSP_DEPTH  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .rsp_store    (rsp_store),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Synchronous RAM; dout is scrambled on idle cycles so a late sample shows up.
  logic [31:0] ramArray [128];
  logic        ramLoad;

  function automatic logic [7:0] initByte(input int b);
    return 8'((b * 37 + 11) ^ (b >> 3));
  endfunction

  always @(posedge clk) begin
    if (ramLoad) begin
      for (int w = 0; w < 128; w++)
        for (int k = 0; k < 4; k++)
          ramArray[w][8*k +: 8] <= initByte(4 * w + k);
    end else if (ram_en) begin
      for (int k = 0; k < 4; k++)
        if (ram_we[k]) ramArray[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
    end
    ram_dout <= ram_en ? ramArray[ram_addr] : $urandom();
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        store;
    int          acc;
  } expRsp_t;

  logic [7:0] refMem [512];
  expRsp_t    expQ [$];
  expRsp_t    newRsp;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         acceptCount = 0;
  bit         randomRsp = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit isErr(input logic [1:0] size, input logic [8:0] a);
    if (size == 2'b11) return 1'b1;
    return (int'(a) % sizeBytes(size)) != 0;
  endfunction

  // Reference: a transaction is seen at the falling edge before the edge that
  // accepts it; its response may appear no earlier than two cycles later.
  logic        mAcc, mErr, mValid;
  logic [3:0]  mMask;
  int          mN, mOff;
  logic [31:0] mVal;

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rstRspValid", rsp_valid, 0);
      checkOutput("rstReqReady", req_ready, 1);
      checkOutput("rstRspRdata", rsp_rdata, 0);
      checkOutput("rstRspErr", rsp_err, 0);
      checkOutput("rstRspStore", rsp_store, 0);
      checkOutput("rstRamWe", ram_we, 0);
      expQ.delete();
    end else begin
      cyc++;
      checkOutput("reqReady", req_ready, expQ.size() < 3);
      mValid = (expQ.size() > 0) && (cyc >= expQ[0].acc + 2);
      checkOutput("rspValid", rsp_valid, mValid);
      if (mValid && rsp_valid) begin
        checkOutput("rspRdata", rsp_rdata, expQ[0].rdata);
        checkOutput("rspErr", rsp_err, expQ[0].err);
        checkOutput("rspStore", rsp_store, expQ[0].store);
      end

      mAcc  = req_valid && (expQ.size() < 3);
      mErr  = isErr(req_size, req_addr);
      mN    = sizeBytes(req_size);
      mOff  = int'(req_addr) % 4;
      mMask = 4'b0000;
      if (mAcc && !mErr && req_we)
        for (int k = 0; k < mN; k++) mMask[mOff + k] = 1'b1;

      checkOutput("ramEn", ram_en, mAcc && !mErr);
      checkOutput("ramWe", ram_we, mMask);
      if (mAcc && !mErr) begin
        checkOutput("ramAddr", ram_addr, req_addr / 4);
        if (req_we)
          for (int k = 0; k < mN; k++)
            checkOutput("ramDin", ram_din[8*(mOff + k) +: 8], req_wdata[8*k +: 8]);
      end

      if (mValid && rsp_ready) void'(expQ.pop_front());

      if (mAcc) begin
        acceptCount++;
        newRsp.rdata = 32'h0;
        newRsp.err   = mErr;
        newRsp.store = req_we;
        newRsp.acc   = cyc;
        if (!mErr && req_we) begin
          for (int k = 0; k < mN; k++) refMem[int'(req_addr) + k] = req_wdata[8*k +: 8];
        end else if (!mErr) begin
          mVal = 32'h0;
          for (int k = 0; k < mN; k++) mVal[8*k +: 8] = refMem[int'(req_addr) + k];
          if (!req_unsigned && mN < 4 && mVal[8*mN - 1])
            for (int k = mN; k < 4; k++) mVal[8*k +: 8] = 8'hFF;
          newRsp.rdata = mVal;
        end
        expQ.push_back(newRsp);
      end
    end
  end

  // Present one request and hold it until accepted; returns just after the
  // accepting edge so a following call continues back-to-back.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [8:0] addr, input logic [31:0] wdata);
    int waited;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    waited       = 0;
    @(negedge clk);
    while (!req_ready && waited < 60) begin
      @(posedge clk);
      #1;
      if (randomRsp) rsp_ready = 1'($urandom_range(0, 1));
      waited++;
      @(negedge clk);
    end
    if (!req_ready) checkOutput("acceptTimeout", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (randomRsp) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (randomRsp) rsp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  int acceptsBefore;

  initial begin
    rst          = 1'b1;
    ramLoad      = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    for (int b = 0; b < 512; b++) refMem[b] = initByte(b);
    repeat (2) @(posedge clk);
    #1;
    ramLoad = 1'b0;
    rst     = 1'b0;
    idle(2);

    $display("[TB] word store/load");
    applyStimulus(1, 2'b10, 0, 9'h010, 32'hDEADBEEF);
    applyStimulus(0, 2'b10, 0, 9'h010, 32'h0);
    idle(4);

    $display("[TB] byte store, signed and unsigned byte loads");
    applyStimulus(1, 2'b00, 0, 9'h013, 32'h123456A5);
    applyStimulus(0, 2'b00, 0, 9'h013, 32'h0);
    applyStimulus(0, 2'b00, 1, 9'h013, 32'h0);
    applyStimulus(0, 2'b01, 0, 9'h012, 32'h0);
    idle(4);

    $display("[TB] error requests");
    applyStimulus(0, 2'b01, 0, 9'h011, 32'h0);
    applyStimulus(0, 2'b10, 0, 9'h012, 32'h0);
    applyStimulus(1, 2'b11, 0, 9'h000, 32'hFFFFFFFF);
    idle(4);

    $display("[TB] back-to-back loads");
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 2'b10, 0, 9'(4 * $urandom_range(0, 127)), 32'h0);
    idle(4);

    $display("[TB] response backpressure");
    rsp_ready     = 1'b0;
    acceptsBefore = acceptCount;
    req_we        = 1'b0;
    req_size      = 2'b01;
    req_unsigned  = 1'b0;
    req_addr      = 9'h022;
    req_valid     = 1'b1;
    idle(6);
    req_valid = 1'b0;
    checkOutput("stallAccepts", acceptCount - acceptsBefore, 3);
    idle(2);
    rsp_ready = 1'b1;
    idle(5);

    $display("[TB] reset with requests in flight");
    applyStimulus(0, 2'b10, 0, 9'h040, 32'h0);
    applyStimulus(0, 2'b00, 0, 9'h041, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    $display("[TB] randomized traffic");
    randomRsp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)),
                    9'($urandom_range(0, 511)),
                    $urandom());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    randomRsp = 1'b0;
    rsp_ready = 1'b1;
    idle(10);
    checkOutput("drainEmpty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
